// File: rtl/uart2vga_pkg.sv
// Shared constants and state type for the UART-to-VGA framebuffer path.
// FRAME_CLEAR_EN adds the power-up clear state to the writer FSM.
package uart2vga_pkg;

  localparam int DEF_WIDTH    = 640;
  localparam int DEF_HEIGHT   = 480;
  localparam int DEF_PIX_BITS = 3;
  localparam int ADDR_W       = 19;
  localparam int MAX_ADDR     = DEF_WIDTH * DEF_HEIGHT;
  localparam int COL_W        = 10;
  localparam int ROW_W        = 9;

`ifdef FRAME_CLEAR_EN
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WRITE = 2'd2
  } wr_state_e;
`else
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } wr_state_e;
`endif

  // First framebuffer address of a given row.
  function automatic logic [ADDR_W-1:0] row_base(input logic [ROW_W-1:0] row, input int width);
    row_base = ADDR_W'(row) * ADDR_W'(width);
  endfunction

endpackage

// File: rtl/uart_row_writer_if.sv
// Line-in / framebuffer-out bundle of the row writer.
interface uart_row_writer_if import uart2vga_pkg::*; #(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PIX_BITS = DEF_PIX_BITS
);

  logic                      line_valid;
  logic [ROW_W-1:0]          line_row;
  logic [WIDTH*PIX_BITS-1:0] line_data;
  logic                      line_ready;
  logic [ADDR_W-1:0]         ram_addr;
  logic [PIX_BITS-1:0]       ram_data;
  logic                      ram_wren;
  logic                      line_done;
  logic                      frame_done;
  logic                      row_err;

  modport master (
    output line_valid, line_row, line_data,
    input  line_ready, ram_addr, ram_data, ram_wren, line_done, frame_done, row_err
  );

  modport slave (
    input  line_valid, line_row, line_data,
    output line_ready, ram_addr, ram_data, ram_wren, line_done, frame_done, row_err
  );

endinterface

// File: rtl/uart_row_writer.sv
// Streams one packed pixel line per accepted strobe into the framebuffer, one pixel per cycle.
// Define FRAME_CLEAR_EN to zero the whole frame after reset before accepting lines.
module uart_row_writer import uart2vga_pkg::*; #(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int HEIGHT   = DEF_HEIGHT,
  parameter int PIX_BITS = DEF_PIX_BITS
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  uart_row_writer_if.slave  bus
);

  localparam int                LINE_W   = WIDTH * PIX_BITS;
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(HEIGHT - 1);
  localparam logic [ROW_W:0]    ROW_LIM  = (ROW_W + 1)'(HEIGHT);

`ifdef FRAME_CLEAR_EN
  localparam wr_state_e         RST_STATE = ST_CLEAR;
  localparam logic [ADDR_W-1:0] CLR_END   = ADDR_W'(WIDTH * HEIGHT);
  logic [ADDR_W-1:0] clr_r, clr_s;
`else
  localparam wr_state_e         RST_STATE = ST_IDLE;
`endif

  wr_state_e           state_r, state_s;
  logic [COL_W-1:0]    col_r, col_s;
  logic [LINE_W-1:0]   shift_r, shift_s;
  logic                last_row_r, last_row_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic [PIX_BITS-1:0] data_r, data_s;
  logic                wren_r, wren_s;
  logic                ready_r, ready_s;
  logic                done_r, done_s;
  logic                frame_r, frame_s;
  logic                err_r, err_s;
  logic                accept_s;
  logic                row_ok_s;

  assign accept_s = bus.line_valid && ready_r;
  assign row_ok_s = ({1'b0, bus.line_row} < ROW_LIM);

  // Next-state and next-output decode; write outputs are precomputed so they leave on flops.
  always_comb begin
    state_s    = state_r;
    col_s      = col_r;
    shift_s    = shift_r;
    last_row_s = last_row_r;
    addr_s     = '0;
    data_s     = '0;
    wren_s     = 1'b0;
    ready_s    = 1'b0;
    done_s     = 1'b0;
    frame_s    = 1'b0;
    err_s      = 1'b0;
`ifdef FRAME_CLEAR_EN
    clr_s      = clr_r;
`endif
    case (state_r)
`ifdef FRAME_CLEAR_EN
      ST_CLEAR: begin
        if (clr_r == CLR_END) begin
          state_s = ST_IDLE;
          ready_s = 1'b1;
          clr_s   = '0;
        end else begin
          wren_s = 1'b1;
          addr_s = clr_r;
          clr_s  = clr_r + ADDR_W'(1);
        end
      end
`endif
      ST_IDLE: begin
        ready_s = 1'b1;
        if (accept_s && row_ok_s) begin
          // Column 0 is emitted straight from the input; the shadow keeps the rest.
          state_s    = ST_WRITE;
          ready_s    = 1'b0;
          col_s      = '0;
          wren_s     = 1'b1;
          addr_s     = row_base(bus.line_row, WIDTH);
          data_s     = bus.line_data[PIX_BITS-1:0];
          shift_s    = bus.line_data >> PIX_BITS;
          last_row_s = (bus.line_row == ROW_LAST);
        end else if (accept_s) begin
          err_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (col_r == COL_LAST) begin
          state_s = ST_IDLE;
          col_s   = '0;
          ready_s = 1'b1;
          done_s  = 1'b1;
          frame_s = last_row_r;
        end else begin
          col_s   = col_r + COL_W'(1);
          wren_s  = 1'b1;
          addr_s  = addr_r + ADDR_W'(1);
          data_s  = shift_r[PIX_BITS-1:0];
          shift_s = shift_r >> PIX_BITS;
        end
      end
      default: begin
        state_s = RST_STATE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_r    <= RST_STATE;
      col_r      <= '0;
      shift_r    <= '0;
      last_row_r <= 1'b0;
      addr_r     <= '0;
      data_r     <= '0;
      wren_r     <= 1'b0;
      ready_r    <= 1'b0;
      done_r     <= 1'b0;
      frame_r    <= 1'b0;
      err_r      <= 1'b0;
`ifdef FRAME_CLEAR_EN
      clr_r      <= '0;
`endif
    end else begin
      state_r    <= state_s;
      col_r      <= col_s;
      shift_r    <= shift_s;
      last_row_r <= last_row_s;
      addr_r     <= addr_s;
      data_r     <= data_s;
      wren_r     <= wren_s;
      ready_r    <= ready_s;
      done_r     <= done_s;
      frame_r    <= frame_s;
      err_r      <= err_s;
`ifdef FRAME_CLEAR_EN
      clr_r      <= clr_s;
`endif
    end
  end

  assign bus.line_ready = ready_r;
  assign bus.ram_addr   = addr_r;
  assign bus.ram_data   = data_r;
  assign bus.ram_wren   = wren_r;
  assign bus.line_done  = done_r;
  assign bus.frame_done = frame_r;
  assign bus.row_err    = err_r;

endmodule
